truth_table_sweeper: RTL and testbench

- Sequential stimulus/checker stage that wraps the two-input AND/NAND (De Morgan) gate block.
- Upstream side: drives every input combination onto the gate's inputs in ascending binary order.
- Downstream side: after a programmable settle time, samples the gate's AND and NAND outputs and compares them against the expected values.
- Reports error count, first failing vector and pass/fail, so the gate is self-checked in hardware instead of by printed truth tables.

---
 rtl/sweeper_pkg.sv | 18 +
 rtl/sat_counter.sv | 22 ++
 rtl/truth_table_sweeper.sv | 109 ++++++++++
 tb/tb_truth_table_sweeper.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/sweeper_pkg.sv
// Shared types and reference function for the AND/NAND truth-table sweeper.
package sweeper_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StSample,
        StDone
    } state_e;

    // Expected AND of the low n bits of v: true only when all of them are set.
    function automatic logic exp_and(input logic [31:0] v, input int unsigned n);
        logic [31:0] mask;
        mask = (n >= 32) ? '1 : ((32'd1 << n) - 32'd1);
        return (v & mask) == mask;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [Width-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives every input vector onto a two-input AND/NAND gate, samples it after a settle
// time and reports error count, first failing vector and pass/fail.
module truth_table_sweeper
    import sweeper_pkg::*;
#(
    parameter int unsigned N_IN   = 2,
    parameter int unsigned SETTLE = 1,
    parameter int unsigned ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [N_IN-1:0]  stim,
    input  logic             dut_and,
    input  logic             dut_nand,
    output logic             busy,
    output logic             sample_valid,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             first_fail_valid,
    output logic [N_IN-1:0]  first_fail_vec
);

    localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_e          state_q, state_d;
    logic [CntW-1:0] settle_cnt;
    logic            exp_a;
    logic            mismatch;
    logic            last_vec;
    logic            accept;

    always_comb begin
        exp_a    = exp_and(32'(stim), N_IN);
        // Case inequality so X/Z from the gate counts as a mismatch.
        mismatch = (dut_and !== exp_a) || (dut_nand !== ~exp_a);
        last_vec = (stim == '1);
        accept   = (state_q == StIdle) && start;
        sample_valid = (state_q == StSample);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StSettle;
            StSettle: if (settle_cnt == CntW'(SETTLE - 1)) state_d = StSample;
            StSample: state_d = last_vec ? StDone : StSettle;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StIdle;
            stim             <= '0;
            settle_cnt       <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
        end else begin
            state_q <= state_d;
            done    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        stim             <= '0;
                        settle_cnt       <= '0;
                        first_fail_valid <= 1'b0;
                        busy             <= 1'b1;
                        pass             <= 1'b0;
                    end
                end
                StSettle: settle_cnt <= settle_cnt + 1'b1;
                StSample: begin
                    if (mismatch && !first_fail_valid) begin
                        first_fail_vec   <= stim;
                        first_fail_valid <= 1'b1;
                    end
                    if (!last_vec) begin
                        stim       <= stim + 1'b1;
                        settle_cnt <= '0;
                    end
                end
                StDone: begin
                    // err_count already includes the final sample by this edge.
                    done <= 1'b1;
                    pass <= (err_count == '0);
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    sat_counter #(
        .Width(ERR_W)
    ) u_err_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (accept),
        .inc  (sample_valid && mismatch),
        .count(err_count)
    );

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (SETTLE=1/ERR_W=8 and SETTLE=3/ERR_W=1)
// share a table-driven gate model; table vectors, random gates and corner sequences.
module tb_truth_table_sweeper;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] and_tbl = 4'b1000;
    logic [3:0] nand_tbl = 4'b0111;

    logic [1:0] stim0, ffv_vec0, stim1, ffv_vec1;
    logic       busy0, sv0, done0, pass0, ffv0;
    logic       busy1, sv1, done1, pass1, ffv1;
    logic [7:0] err0;
    logic [0:0] err1;

    int n_checks = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    truth_table_sweeper #(.N_IN(2), .SETTLE(1), .ERR_W(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .stim(stim0),
        .dut_and(and_tbl[stim0]), .dut_nand(nand_tbl[stim0]),
        .busy(busy0), .sample_valid(sv0), .done(done0), .pass(pass0),
        .err_count(err0), .first_fail_valid(ffv0), .first_fail_vec(ffv_vec0)
    );

    truth_table_sweeper #(.N_IN(2), .SETTLE(3), .ERR_W(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .stim(stim1),
        .dut_and(and_tbl[stim1]), .dut_nand(nand_tbl[stim1]),
        .busy(busy1), .sample_valid(sv1), .done(done1), .pass(pass1),
        .err_count(err1), .first_fail_valid(ffv1), .first_fail_vec(ffv_vec1)
    );

    typedef struct {
        string      name;
        logic [3:0] a_tbl;
        logic [3:0] n_tbl;
        int         err;
        int         fv;
        bit         fvv;
        bit         pass;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: AND is 1 only for the all-ones vector, NAND is its inverse.
    task automatic model(input logic [3:0] a, input logic [3:0] n,
                         output int err, output int fv, output bit fvv);
        err = 0; fv = 0; fvv = 0;
        for (int v = 0; v < 4; v++) begin
            bit e;
            e = (v == 3);
            if (a[v] != e || n[v] != !e) begin
                err++;
                if (!fvv) begin
                    fvv = 1;
                    fv  = v;
                end
            end
        end
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_busy"}, busy0, 0);
        chk({tag, "_stim"}, stim0, 0);
        chk({tag, "_err"}, err0, 0);
        chk({tag, "_done"}, done0, 0);
        chk({tag, "_sv"}, sv0, 0);
        chk({tag, "_pass"}, pass0, 0);
        chk({tag, "_ffv"}, ffv0, 0);
        chk({tag, "_ffvec"}, ffv_vec0, 0);
        chk({tag, "_err1"}, err1, 0);
        chk({tag, "_busy1"}, busy1, 0);
    endtask

    task automatic run_sweep(input string name, input int exp_err, input int exp_fv,
                             input bit exp_fvv, input bit exp_pass, input int restart_at);
        int k, d0_at, d1_at, samples0;
        k = 0; d0_at = -1; d1_at = -1; samples0 = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        while (k < 40 && (d0_at < 0 || d1_at < 0)) begin
            @(posedge clk);
            #1;
            k++;
            start = 1'b0;
            if (k == restart_at) start = 1'b1;
            if (sv0) begin
                chk({name, "_stim_seq"}, stim0, samples0);
                samples0++;
            end
            if (done0 && d0_at < 0) d0_at = k;
            if (done1 && d1_at < 0) d1_at = k;
        end
        chk({name, "_done0_cycle"}, d0_at, 9);
        chk({name, "_done1_cycle"}, d1_at, 17);
        chk({name, "_samples0"}, samples0, 4);
        chk({name, "_err0"}, err0, exp_err);
        chk({name, "_err1_sat"}, err1, (exp_err > 0) ? 1 : 0);
        chk({name, "_ffv0"}, ffv0, exp_fvv);
        chk({name, "_ffv1"}, ffv1, exp_fvv);
        if (exp_fvv) begin
            chk({name, "_ffvec0"}, ffv_vec0, exp_fv);
            chk({name, "_ffvec1"}, ffv_vec1, exp_fv);
        end
        chk({name, "_pass0"}, pass0, exp_pass);
        chk({name, "_pass1"}, pass1, exp_pass);
        chk({name, "_busy0"}, busy0, 0);
        chk({name, "_stim_hold"}, stim0, 3);
    endtask

    initial begin
        int   e, f, k, seen;
        bit   fvv;

        tbl[0] = '{"good",      4'b1000, 4'b0111, 0, 0, 1'b0, 1'b1};
        tbl[1] = '{"and_stuck0", 4'b0000, 4'b0111, 1, 3, 1'b1, 1'b0};
        tbl[2] = '{"nand_is_or", 4'b1000, 4'b1110, 2, 0, 1'b1, 1'b0};
        tbl[3] = '{"all_wrong",  4'b0111, 4'b1000, 4, 0, 1'b1, 1'b0};

        #1;
        all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            and_tbl  = tbl[i].a_tbl;
            nand_tbl = tbl[i].n_tbl;
            run_sweep(tbl[i].name, tbl[i].err, tbl[i].fv, tbl[i].fvv, tbl[i].pass, -1);
        end

        // start pulsed while busy must not restart the sweep
        and_tbl = 4'b1000; nand_tbl = 4'b0111;
        run_sweep("restart_ignored", 0, 0, 1'b0, 1'b1, 4);

        // reset mid-sweep with a failing gate
        and_tbl = 4'b0111; nand_tbl = 4'b1000;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
        end
        chk("pre_rst_err", err0, 2);
        chk("pre_rst_busy", busy0, 1);
        rst_n = 1'b0;
        #1;
        all_zero("mid_rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (done0 || done1) seen++;
        end
        chk("no_done_after_rst", seen, 0);
        and_tbl = 4'b1000; nand_tbl = 4'b0111;
        run_sweep("after_rst", 0, 0, 1'b0, 1'b1, -1);

        for (int r = 0; r < 12; r++) begin
            and_tbl  = 4'($urandom);
            nand_tbl = 4'($urandom);
            model(and_tbl, nand_tbl, e, f, fvv);
            run_sweep($sformatf("rand%0d", r), e, f, fvv, (e == 0), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
